seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse companion of the 4x4 combinational Multiplier.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Uses a start/busy/done handshake so the datapath controller can issue divisions next to multiplications.
- Result satisfies a = q*b + r with r < b, for any b != 0.

---
 rtl/seq_divider.sv | 148 ++++++++++++++
 tb/tb_seq_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider. Produces one quotient
//               bit per clock behind a start/busy/done handshake; a zero
//               divisor short-circuits to an all-ones quotient with
//               remainder = dividend and a div_by_zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  localparam int c_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [WIDTH-1:0]     r_dividend, w_dividend_nxt;
  logic [WIDTH-1:0]     r_divisor,  w_divisor_nxt;
  logic [WIDTH:0]       r_rem,      w_rem_nxt;
  logic [WIDTH-1:0]     r_quot,     w_quot_nxt;
  logic [c_CNT_W-1:0]   r_count,    w_count_nxt;
  logic [WIDTH-1:0]     w_q_nxt;
  logic [WIDTH-1:0]     w_r_nxt;
  logic                 w_dbz_nxt;

  // One restoring step: bring in the next dividend bit, then trial-subtract
  // at WIDTH+1 bits so the shifted remainder can never overflow.
  logic [WIDTH:0]       w_rem_shift;
  logic [WIDTH:0]       w_rem_sub;
  logic                 w_rem_ge;
  logic [WIDTH-1:0]     w_quot_shift;

  assign w_rem_shift  = {r_rem[WIDTH-1:0], r_dividend[WIDTH-1]};
  assign w_rem_ge     = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_sub    = w_rem_shift - {1'b0, r_divisor};
  assign w_quot_shift = {r_quot[WIDTH-2:0], w_rem_ge};

  // After each step rem < divisor, so the remainder MSB and the quotient MSB
  // shifted out on the final step never feed back into the datapath.
  logic [1:0] w_unused_msbs;
  assign w_unused_msbs = {r_rem[WIDTH], r_quot[WIDTH-1]};

  // Status outputs decode the state register only, so no input reaches them.
  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_DONE);

  // State and datapath registers; reset discards any computation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_count     <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dividend  <= w_dividend_nxt;
      r_divisor   <= w_divisor_nxt;
      r_rem       <= w_rem_nxt;
      r_quot      <= w_quot_nxt;
      r_count     <= w_count_nxt;
      q           <= w_q_nxt;
      r           <= w_r_nxt;
      div_by_zero <= w_dbz_nxt;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    w_state_nxt    = r_state;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_rem_nxt      = r_rem;
    w_quot_nxt     = r_quot;
    w_count_nxt    = r_count;
    w_q_nxt        = q;
    w_r_nxt        = r;
    w_dbz_nxt      = div_by_zero;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_dividend_nxt = a;
          w_divisor_nxt  = b;
          w_rem_nxt      = '0;
          w_quot_nxt     = '0;
          w_count_nxt    = c_CNT_W'(WIDTH);
          if (b != '0) begin
            w_state_nxt = S_CALC;
          end else begin
            // Zero divisor: publish the defined fallback result at once.
            w_q_nxt     = '1;
            w_r_nxt     = a;
            w_dbz_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end

      S_CALC: begin
        w_dividend_nxt = r_dividend << 1;
        w_rem_nxt      = w_rem_ge ? w_rem_sub : w_rem_shift;
        w_quot_nxt     = w_quot_shift;
        w_count_nxt    = r_count - c_CNT_W'(1);
        if (r_count == c_CNT_W'(1)) begin
          // Last bit: results become visible together with done.
          w_q_nxt     = w_quot_shift;
          w_r_nxt     = w_rem_nxt[WIDTH-1:0];
          w_dbz_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH=4). Directed
//               handshake scenarios, an exhaustive operand sweep and random
//               operands, all checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int WIDTH = 4;
  localparam int c_MAXV = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  // Last published result, expected to stay on the outputs during a new CALC.
  int hold_q   = 0;
  int hold_r   = 0;
  int hold_dbz = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  function automatic void model(input int ta, input int tb_, output int eq, output int er, output int ed);
    if (tb_ == 0) begin
      eq = c_MAXV;
      er = ta;
      ed = 1;
    end else begin
      eq = ta / tb_;
      er = ta % tb_;
      ed = 0;
    end
  endfunction

  // One request with a single-cycle start; checks timing, hold and result.
  task automatic run_div(input int ta, input int tb_);
    int eq, er, ed, cyc, nb;
    logic [31:0] tv;
    model(ta, tb_, eq, er, ed);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    tv = ta; a = tv[WIDTH-1:0];
    tv = tb_; b = tv[WIDTH-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    cyc = 1;
    nb  = 0;
    while (!done && cyc < 20) begin
      if (busy) nb++;
      chk("hold_q", q, hold_q);
      chk("hold_r", r, hold_r);
      chk("hold_dbz", div_by_zero, hold_dbz);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("latency", cyc, (tb_ != 0) ? WIDTH + 1 : 1);
    chk("busy_cycles", nb, (tb_ != 0) ? WIDTH : 0);
    chk("q", q, eq);
    chk("r", r, er);
    chk("dbz", div_by_zero, ed);
    if (tb_ != 0) begin
      chk("identity", int'(q) * tb_ + int'(r), ta);
      chk("r_lt_b", (int'(r) < tb_) ? 1 : 0, 1);
    end
    hold_q   = eq;
    hold_r   = er;
    hold_dbz = ed;
  endtask

  initial begin
    int cyc, ndone;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    // Basic and back-to-back requests, divide by zero and recovery.
    run_div(13, 3);
    run_div(15, 1);
    run_div(5, 7);
    run_div(9, 0);
    run_div(8, 2);

    // start held high with changing operands during CALC must be ignored.
    @(negedge clk);
    a = 4'd14; b = 4'd4; start = 1'b1;
    @(negedge clk);
    a = 4'd1; b = 4'd1;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("hs_done_seen", done, 1);
    chk("hs_latency", cyc, WIDTH + 1);
    chk("hs_q", q, 3);
    chk("hs_r", r, 2);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("hs_extra_done", ndone, 0);
    hold_q = 3; hold_r = 2; hold_dbz = 0;

    // Reset pulse mid-CALC clears outputs asynchronously, no done follows.
    @(negedge clk);
    a = 4'd11; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_r", r, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("post_rst_idle", ndone, 0);
    hold_q = 0; hold_r = 0; hold_dbz = 0;
    run_div(11, 2);

    // Every operand pair, then a batch of random ones.
    for (int ia = 0; ia <= c_MAXV; ia++) begin
      for (int ib = 0; ib <= c_MAXV; ib++) begin
        run_div(ia, ib);
      end
    end
    repeat (40) begin
      run_div(int'($urandom_range(0, c_MAXV)), int'($urandom_range(0, c_MAXV)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
